csa_resolver: RTL and testbench

CSA_RESOLVER -- requirements
Module: csa_resolver

---
 rtl/csa_resolver.sv | 127 ++++++++++++
 tb/tb_csa_resolver.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/csa_resolver.sv
// Carry-save resolver: adds a sum/carry vector pair CHUNK bits per cycle and
// holds the WIDTH-bit result plus carry-out under a valid/ready handshake.
module csa_resolver #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int unsigned NChunks = WIDTH / CHUNK;
  localparam int unsigned IdxW    = (NChunks > 1) ? $clog2(NChunks) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NChunks - 1);

  if (WIDTH % CHUNK != 0) begin : gen_bad_chunk
    $error("csa_resolver: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  opa_q, opa_d, opb_q, opb_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              rc_q, rc_d;
  logic              cout_q, cout_d;
  logic              valid_q, valid_d;
  logic [CHUNK:0]    chunk_sum;
  logic              last_chunk;

  // Operands shift down each cycle so the active chunk is always the low CHUNK bits.
  assign chunk_sum  = {1'b0, opa_q[CHUNK-1:0]} + {1'b0, opb_q[CHUNK-1:0]}
                    + {{CHUNK{1'b0}}, rc_q};
  assign last_chunk = (idx_q == LastIdx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid)   state_d = StAdd;
      StAdd:   if (last_chunk) state_d = StDone;
      StDone:  if (out_ready)  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready = (state_q == StIdle);
    busy     = (state_q != StIdle);
  end

  always_comb begin
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    idx_d    = idx_q;
    rc_d     = rc_q;
    cout_d   = cout_q;
    valid_d  = valid_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          opa_d = in_sum;
          opb_d = in_carry;
          idx_d = '0;
          rc_d  = 1'b0;
        end
      end
      StAdd: begin
        result_d[idx_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
        rc_d  = chunk_sum[CHUNK];
        idx_d = idx_q + 1'b1;
        opa_d = opa_q >> CHUNK;
        opb_d = opb_q >> CHUNK;
        if (last_chunk) begin
          cout_d  = chunk_sum[CHUNK];
          valid_d = 1'b1;
        end
      end
      StDone: begin
        if (out_ready) valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      idx_q    <= '0;
      rc_q     <= 1'b0;
      cout_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      rc_q     <= rc_d;
      cout_q   <= cout_d;
      valid_q  <= valid_d;
    end
  end

  assign result    = result_q;
  assign carry_out = cout_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_csa_resolver.sv
// Scoreboard bench for csa_resolver: driver pushes expected sums, a negedge
// monitor pops and compares on each output transfer.
module tb_csa_resolver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] in_sum = '0;
  logic [63:0] in_carry = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] result;
  logic        carry_out;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;

  csa_resolver #(.WIDTH(64), .CHUNK(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_sum   (in_sum),
    .in_carry (in_carry),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .result   (result),
    .carry_out(carry_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [64:0] exp;
    int          acc;
  } item_t;

  item_t sb[$];
  int    cyc = 0;
  int    total = 0;
  int    bad = 0;
  int    n_acc = 0;
  int    n_out = 0;
  int    rdy_mode = 1;  // 0 = hold low, 1 = hold high, 2 = random
  bit    lat_chk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    out_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : rdy_mode[0];
  end

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: transfer happens on the posedge following a negedge with valid & ready.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", 65'd1, 65'd0);
      end else begin
        if (!lat_chk) begin
          check("latency", 65'(cyc - sb[0].acc), 65'd4);
          lat_chk = 1'b1;
        end
        if (out_ready) begin
          check("result", {carry_out, result}, sb[0].exp);
          void'(sb.pop_front());
          lat_chk = 1'b0;
          n_out++;
        end
      end
    end
  end

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [64:0] exp,
                      input bit push, input bit junk);
    int guard = 0;
    @(negedge clk);
    while (!in_ready) begin
      @(negedge clk);
      guard++;
      if (guard > 200) begin
        $display("FAIL in_ready_timeout: got 0 want 1");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "in_ready never returned");
      end
    end
    in_sum   = a;
    in_carry = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    if (push) begin
      sb.push_back('{exp, cyc});
      n_acc++;
    end
    if (junk) begin
      repeat (4) begin
        in_sum   = {$urandom, $urandom};
        in_carry = {$urandom, $urandom};
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    check("drain_timeout", 65'(sb.size()), 65'd0);
  endtask

  initial begin
    logic        seen;
    logic [63:0] a;
    logic [63:0] b;

    #2;
    check("rst_in_ready", 65'(in_ready), 65'd1);
    check("rst_busy", 65'(busy), 65'd0);
    check("rst_out_valid", 65'(out_valid), 65'd0);
    check("rst_result", {carry_out, result}, 65'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    send(64'h5, 64'hA, 65'h0_0000_0000_0000_000F, 1'b1, 1'b0);
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 65'h1_0000_0000_0000_0000, 1'b1, 1'b0);
    send(64'hFFFF, 64'h1, 65'h0_0000_0000_0001_0000, 1'b1, 1'b0);
    send(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 65'h0_2222_2222_2222_2211,
         1'b1, 1'b0);
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 65'h1_FFFF_FFFF_FFFF_FFFE,
         1'b1, 1'b0);
    send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 65'h1_0000_0000_0000_0000,
         1'b1, 1'b0);
    // Operands change to junk while ADD runs; result must track captured values.
    send(64'h0000_0001_0000_0003, 64'h0000_0002_0000_0004, 65'h0_0000_0003_0000_0007,
         1'b1, 1'b1);
    drain();

    // Backpressure hold in DONE.
    rdy_mode = 0;
    send(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3211, 65'h1_0000_0000_0000_0000,
         1'b1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    check("bp_valid_seen", 65'(seen), 65'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 65'(out_valid), 65'd1);
      check("bp_hold_data", {carry_out, result}, 65'h1_0000_0000_0000_0000);
      check("bp_in_ready", 65'(in_ready), 65'd0);
    end
    rdy_mode = 1;
    drain();
    @(negedge clk);
    check("bp_after_valid", 65'(out_valid), 65'd0);
    check("bp_after_ready", 65'(in_ready), 65'd1);

    // Reset just before the second ADD edge.
    send(64'h0000_0000_0000_1234, 64'h0000_0000_0000_1111, 65'd0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_result", {carry_out, result}, 65'd0);
    check("mid_rst_valid", 65'(out_valid), 65'd0);
    check("mid_rst_in_ready", 65'(in_ready), 65'd1);
    check("mid_rst_busy", 65'(busy), 65'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    check("mid_rst_no_valid", 65'(seen), 65'd0);
    send(64'h7, 64'h9, 65'h0_0000_0000_0000_0010, 1'b1, 1'b0);
    drain();

    // Random operands with random backpressure.
    rdy_mode = 2;
    for (int i = 0; i < 2000; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      send(a, b, {1'b0, a} + {1'b0, b}, 1'b1, (i % 7) == 0);
    end
    drain();
    check("one_out_per_accept", 65'(n_out), 65'(n_acc));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
